float_result_buffer: RTL and testbench

Output-side buffer placed directly downstream of `float_alu`. Accepts each completed result/flags pair over a valid/ready handshake, queues it in a small FIFO, and presents it in order to the consumer (register-file writeback or bus interface). Also keeps a sticky accumulated-exception register (`fflags`), OR-ing in the flags of every accepted result until software clears it.

---
 rtl/float_result_buffer.sv | 46 ++++
 tb/tb_float_result_buffer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/float_result_buffer.sv
// float_result_buffer: FIFO of ALU result/flags pairs with a sticky accumulated-exception register.
module float_result_buffer #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [31:0]   result_in,
  input  logic [4:0]    flags_in,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [31:0]   result,
  output logic [4:0]    flags,
  output logic [4:0]    fflags,
  input  logic          fflags_clr,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [36:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  always_comb begin
    ready_out = count != CW'(DEPTH);
    valid_out = count != '0;
    push = valid_in && ready_out;
    pop = valid_out && ready_in;
    {result, flags} = valid_out ? mem[rd_ptr] : 37'd0;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {result_in, flags_in};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      fflags <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      fflags <= ((fflags_clr ? 5'd0 : fflags) | (push ? flags_in : 5'd0));
    end
  end
endmodule

// File: tb/tb_float_result_buffer.sv
// tb_float_result_buffer: directed checks of FIFO order, full/empty behaviour, sticky flags and reset.
module tb_float_result_buffer;
  logic clk = 0, rst = 1, valid_in = 0, ready_in = 0, fflags_clr = 0;
  logic ready_out, valid_out;
  logic [31:0] result_in = 0, result;
  logic [4:0] flags_in = 0, flags, fflags;
  logic [2:0] count;
  int tests = 0, fails = 0;
  logic [31:0] v [4] = '{32'h3E99_999A, 32'h7F80_0000, 32'h7FC0_0000, 32'h3FE0_0000};
  logic [4:0] f [4] = '{5'b00001, 5'b00101, 5'b10000, 5'b00000};

  float_result_buffer dut (.clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .result_in(result_in), .flags_in(flags_in), .valid_out(valid_out), .ready_in(ready_in),
    .result(result), .flags(flags), .fflags(fflags), .fflags_clr(fflags_clr), .count(count));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  initial begin
    step();
    rst = 0;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_count", count, 0);
    chk("rst_fflags", fflags, 0);
    valid_in = 1; result_in = 32'h41B8_0000; flags_in = 0;
    step();
    valid_in = 0;
    chk("one_valid", valid_out, 1);
    chk("one_result", result, 32'h41B8_0000);
    chk("one_count", count, 1);
    chk("one_fflags", fflags, 0);
    ready_in = 1;
    step();
    ready_in = 0;
    chk("pop_valid", valid_out, 0);
    chk("pop_result", result, 0);
    chk("pop_count", count, 0);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1; result_in = v[i]; flags_in = f[i];
      step();
    end
    chk("full_count", count, 4);
    chk("full_ready", ready_out, 0);
    chk("full_fflags", fflags, 5'b10101);
    result_in = 32'h4049_0FDB; flags_in = 5'b00010;
    step();
    step();
    chk("held_count", count, 4);
    chk("held_fflags", fflags, 5'b10101);
    chk("head0", result, v[0]);
    chk("head0_flags", flags, f[0]);
    ready_in = 1;
    step();
    chk("fullpop_count", count, 3);
    chk("fullpop_ready", ready_out, 1);
    chk("head1", result, v[1]);
    step();
    valid_in = 0;
    chk("pushpop_count", count, 3);
    chk("fifth_fflags", fflags, 5'b10111);
    chk("head2", result, v[2]);
    chk("head2_flags", flags, f[2]);
    step();
    chk("head3", result, v[3]);
    chk("drain_count", count, 2);
    step();
    chk("head_fifth", result, 32'h4049_0FDB);
    chk("head_fifth_flags", flags, 5'b00010);
    step();
    chk("drained_valid", valid_out, 0);
    chk("drained_count", count, 0);
    valid_in = 1; flags_in = 0;
    for (int i = 0; i < 11; i++) begin
      result_in = 32'h1000_0000 + i;
      step();
      chk("stream_count", count, 1);
      chk("stream_result", result, 32'h1000_0000 + i);
    end
    valid_in = 0;
    step();
    chk("stream_end_count", count, 0);
    ready_in = 0;
    fflags_clr = 1;
    step();
    fflags_clr = 0;
    chk("clr_alone", fflags, 0);
    valid_in = 1; result_in = 32'hAAAA_0001; flags_in = 5'b10000;
    step();
    chk("sticky_set", fflags, 5'b10000);
    fflags_clr = 1; result_in = 32'hAAAA_0002; flags_in = 5'b00010;
    step();
    chk("clr_push", fflags, 5'b00010);
    valid_in = 0;
    step();
    fflags_clr = 0;
    chk("clr_only", fflags, 0);
    chk("clr_count", count, 2);
    valid_in = 1; result_in = 32'hAAAA_0003; flags_in = 5'b01000;
    step();
    chk("three_count", count, 3);
    rst = 1; ready_in = 1;
    step();
    rst = 0; valid_in = 0; ready_in = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_ready", ready_out, 1);
    chk("mid_rst_fflags", fflags, 0);
    chk("mid_rst_result", result, 0);
    step();
    chk("no_stale_valid", valid_out, 0);
    chk("no_stale_result", result, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
